// File: rtl/mem_port_arbiter_if.sv
// Bundle of request/response and Memory-side signals around the shared memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             if_req;
  logic [WIDTH-1:0] if_addr;
  logic             if_ready;
  logic [WIDTH-1:0] if_rdata;
  logic             dm_req;
  logic             dm_we;
  logic [WIDTH-1:0] dm_addr;
  logic [WIDTH-1:0] dm_wdata;
  logic             dm_ready;
  logic [WIDTH-1:0] dm_rdata;
  logic [WIDTH-1:0] mem_Address;
  logic             mem_ReadEnable;
  logic             mem_WriteEnable;
  logic [WIDTH-1:0] mem_WriteData;
  logic [WIDTH-1:0] mem_ReadData;
  logic             busy;
  logic             owner;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ReadData,
    output if_ready, if_rdata, dm_ready, dm_rdata,
           mem_Address, mem_ReadEnable, mem_WriteEnable, mem_WriteData, busy, owner
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_ReadData,
    input  if_ready, if_rdata, dm_ready, dm_rdata,
           mem_Address, mem_ReadEnable, mem_WriteEnable, mem_WriteData, busy, owner
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one single-port Memory between instruction fetch (IF) and data access (DM):
// DM-priority arbitration with an IF anti-starvation limit, fixed-length access window.
module mem_port_arbiter #(
  parameter int WIDTH        = 32,
  parameter int WAIT_CYCLES  = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;

  localparam logic [3:0] WAIT_LOAD  = 4'(WAIT_CYCLES - 1);
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_t           r_state;
  state_t           w_state_nxt;
  logic             r_owner;
  logic             r_we;
  logic [WIDTH-1:0] r_addr;
  logic [WIDTH-1:0] r_wdata;
  logic [WIDTH-1:0] r_if_rdata;
  logic [WIDTH-1:0] r_dm_rdata;
  logic [3:0]       r_waitcnt;
  logic [3:0]       r_starve;
  logic [3:0]       w_starve_nxt;
  logic             w_grant_any;
  logic             w_grant_dm;
  logic             w_done;

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned (no latch).
  always_comb begin
    w_state_nxt  = r_state;
    w_starve_nxt = r_starve;
    w_grant_any  = 1'b0;
    w_grant_dm   = 1'b0;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_grant_any = bus.if_req | bus.dm_req;
        w_grant_dm  = bus.dm_req & ~(bus.if_req & (r_starve == STARVE_MAX));
        if (w_grant_any) w_state_nxt = ST_ACCESS;
        // Only a DM grant that bypasses a waiting IF advances the starve count.
        if (!bus.if_req || !w_grant_dm)   w_starve_nxt = '0;
        else if (r_starve != STARVE_MAX) w_starve_nxt = r_starve + 4'd1;
      end
      ST_ACCESS: begin
        if (r_waitcnt == '0) begin
          w_done      = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // NOTE: the rdata holding registers are reset as well, since they are visible outputs that must read 0.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_owner    <= 1'b0;
      r_we       <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_waitcnt  <= '0;
      r_starve   <= '0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_starve <= w_starve_nxt;
      if (w_grant_any) begin
        r_owner   <= w_grant_dm;
        r_we      <= w_grant_dm & bus.dm_we;
        r_addr    <= w_grant_dm ? bus.dm_addr : bus.if_addr;
        r_wdata   <= w_grant_dm ? bus.dm_wdata : '0;
        r_waitcnt <= WAIT_LOAD;
      end else if (r_state == ST_ACCESS && r_waitcnt != '0) begin
        r_waitcnt <= r_waitcnt - 4'd1;
      end
      if (w_done && !r_we) begin
        if (r_owner) r_dm_rdata <= bus.mem_ReadData;
        else         r_if_rdata <= bus.mem_ReadData;
      end
    end
  end

  assign bus.mem_ReadEnable  = (r_state == ST_ACCESS) & ~r_we;
  assign bus.mem_WriteEnable = (r_state == ST_ACCESS) & r_we;
  assign bus.mem_Address     = (r_state == ST_ACCESS) ? r_addr : '0;
  assign bus.mem_WriteData   = (r_state == ST_ACCESS && r_we) ? r_wdata : '0;
  assign bus.if_ready        = (r_state == ST_RESP) & ~r_owner;
  assign bus.dm_ready        = (r_state == ST_RESP) & r_owner;
  assign bus.if_rdata        = r_if_rdata;
  assign bus.dm_rdata        = r_dm_rdata;
  assign bus.busy            = (r_state != ST_IDLE);
  assign bus.owner           = r_owner;

endmodule
